// File: rtl/exu_cal_arb_pkg.sv
// exu_cal_arb_pkg: shared encodings and defaults for the exu_cal arbiter
package exu_cal_arb_pkg;
    localparam int CAL_OPB_SIZE = 8;
    localparam int CARB_TMO_W = 6;
    localparam int CARB_AL = 0;
    localparam int CARB_BJ = 1;
    localparam int CARB_AG = 2;
    localparam logic [2:0] CARB_PTR_RST = 3'b001;
    typedef enum logic {CARB_IDLE = 1'b0, CARB_BUSY = 1'b1} carb_state_e;
    function automatic logic [2:0] rr_next(input logic [2:0] g);
        return {g[1:0], g[2]};
    endfunction
endpackage

// File: rtl/exu_cal_rr_pick.sv
// exu_cal_rr_pick: combinational 3-way round-robin picker, search starts at one-hot ptr
module exu_cal_rr_pick
    import exu_cal_arb_pkg::*;
(
    input  logic [2:0] val,
    input  logic [2:0] ptr,
    output logic [2:0] grant
);
    logic [2:0] rv;
    logic [2:0] pg;
    // Rotate so the pointer position lands on bit 0, pick lowest, rotate back.
    always_comb begin
        rv = ptr[CARB_BJ] ? {val[0], val[2], val[1]} : ptr[CARB_AG] ? {val[1], val[0], val[2]} : val;
        pg = rv[0] ? 3'b001 : rv[1] ? 3'b010 : rv[2] ? 3'b100 : 3'b000;
        grant = ptr[CARB_BJ] ? {pg[1], pg[0], pg[2]} : ptr[CARB_AG] ? {pg[0], pg[2], pg[1]} : pg;
    end
endmodule

// File: rtl/exu_cal_arb.sv
// exu_cal_arb: round-robin arbiter sharing exu_cal between ALU, BJU and AGU
module exu_cal_arb
    import exu_cal_arb_pkg::*;
#(
    parameter int OPB_W = CAL_OPB_SIZE,
    parameter int TMO_W = CARB_TMO_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hs_al4cal_val,
    input  logic [OPB_W-1:0] i_al_opb,
    output logic             hs_cal4al_rdy,
    input  logic             hs_bj4cal_val,
    input  logic [OPB_W-1:0] i_bj_opb,
    output logic             hs_cal4bj_rdy,
    input  logic             hs_ag4cal_val,
    input  logic [OPB_W-1:0] i_ag_opb,
    output logic             hs_cal4ag_rdy,
    output logic [31:0]      o_res,
    output logic             hs_arb4cal_val,
    output logic [OPB_W-1:0] o_cal_opb,
    input  logic             hs_cal4arb_rdy,
    input  logic [31:0]      i_cal_res,
    output logic             o_tmo
);
    carb_state_e      state_q, state_d;
    logic [2:0]       grant_q, grant_d, rr_ptr_q, rr_ptr_d, val, pick, rdy;
    logic [OPB_W-1:0] opb_q, opb_d, pick_opb;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d, tmo_inc;
    logic             busy, fire, done;

    assign val = {hs_ag4cal_val, hs_bj4cal_val, hs_al4cal_val};

    exu_cal_rr_pick u_pick (
        .val  (val),
        .ptr  (rr_ptr_q),
        .grant(pick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= CARB_IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= CARB_PTR_RST;
            opb_q     <= '0;
            tmo_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            opb_q     <= opb_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    // Timeout fires on the busy cycle that would bring the counter to all-ones; a completion in that cycle wins.
    always_comb begin
        busy = state_q == CARB_BUSY;
        tmo_inc = tmo_cnt_q + TMO_W'(1);
        fire = busy && !hs_cal4arb_rdy && (&tmo_inc);
        done = busy && (hs_cal4arb_rdy || fire);
        pick_opb = ({OPB_W{pick[CARB_AL]}} & i_al_opb) | ({OPB_W{pick[CARB_BJ]}} & i_bj_opb) | ({OPB_W{pick[CARB_AG]}} & i_ag_opb);
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        opb_d     = opb_q;
        tmo_cnt_d = tmo_cnt_q;
        if (!busy && |val) begin
            state_d   = CARB_BUSY;
            grant_d   = pick;
            opb_d     = pick_opb;
            tmo_cnt_d = '0;
        end else if (done) begin
            state_d   = CARB_IDLE;
            grant_d   = '0;
            rr_ptr_d  = rr_next(grant_q);
            tmo_cnt_d = '0;
        end else if (busy) begin
            tmo_cnt_d = tmo_inc;
        end
    end

    always_comb begin
        rdy            = grant_q & {3{done}};
        hs_cal4al_rdy  = rdy[CARB_AL];
        hs_cal4bj_rdy  = rdy[CARB_BJ];
        hs_cal4ag_rdy  = rdy[CARB_AG];
        hs_arb4cal_val = busy;
        o_cal_opb      = opb_q;
        o_tmo          = fire;
        o_res          = (busy && hs_cal4arb_rdy) ? i_cal_res : 32'h0;
    end
endmodule

// File: tb/tb_exu_cal_arb.sv
// tb_exu_cal_arb: table-driven check of the exu_cal arbiter plus a fairness sequence
module tb_exu_cal_arb;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        al_val = 1'b0, bj_val = 1'b0, ag_val = 1'b0;
    logic [7:0]  al_opb = '0, bj_opb = '0, ag_opb = '0;
    logic        al_rdy, bj_rdy, ag_rdy, arb_val, cal_rdy = 1'b0, tmo;
    logic [7:0]  cal_opb;
    logic [31:0] res, cal_res = '0;
    logic [2:0]  rdy;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic        r;
        logic [2:0]  v;
        logic [7:0]  a, b, g;
        logic        cr;
        logic [31:0] cres;
        logic        ev;
        logic [7:0]  eo;
        logic [2:0]  erdy;
        logic [31:0] eres;
        logic        et;
    } vec_t;
    vec_t vq[$];

    exu_cal_arb #(.OPB_W(8), .TMO_W(3)) dut (
        .clk           (clk),
        .rst           (rst),
        .hs_al4cal_val (al_val),
        .i_al_opb      (al_opb),
        .hs_cal4al_rdy (al_rdy),
        .hs_bj4cal_val (bj_val),
        .i_bj_opb      (bj_opb),
        .hs_cal4bj_rdy (bj_rdy),
        .hs_ag4cal_val (ag_val),
        .i_ag_opb      (ag_opb),
        .hs_cal4ag_rdy (ag_rdy),
        .o_res         (res),
        .hs_arb4cal_val(arb_val),
        .o_cal_opb     (cal_opb),
        .hs_cal4arb_rdy(cal_rdy),
        .i_cal_res     (cal_res),
        .o_tmo         (tmo)
    );

    assign rdy = {ag_rdy, bj_rdy, al_rdy};

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic [2:0] v, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] g, input logic cr, input logic [31:0] cres, input logic ev,
                       input logic [7:0] eo, input logic [2:0] erdy, input logic [31:0] eres, input logic et);
        vec_t t;
        t.r = r; t.v = v; t.a = a; t.b = b; t.g = g; t.cr = cr; t.cres = cres;
        t.ev = ev; t.eo = eo; t.erdy = erdy; t.eres = eres; t.et = et;
        vq.push_back(t);
    endtask

    initial begin
        #1 rst = 1'b1;
        // single request, cal answers on the 4th busy cycle
        add(1, 3'b000, 0, 0, 0, 0, 0, 0, 8'h00, 3'b000, 0, 0);
        add(0, 3'b001, 8'hA1, 0, 0, 0, 0, 0, 8'h00, 3'b000, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 3'b001, 8'hA1, 0, 0, 0, 0, 1, 8'hA1, 3'b000, 0, 0);
        add(0, 3'b001, 8'hA1, 0, 0, 1, 32'h1234, 1, 8'hA1, 3'b001, 32'h1234, 0);
        add(0, 3'b000, 0, 0, 0, 1, 32'hDEAD, 0, 8'hA1, 3'b000, 0, 0);
        add(0, 3'b000, 0, 0, 0, 0, 0, 0, 8'hA1, 3'b000, 0, 0);
        // simultaneous al/bj/ag, two busy cycles each
        add(1, 3'b000, 0, 0, 0, 0, 0, 0, 8'h00, 3'b000, 0, 0);
        add(0, 3'b111, 8'h11, 8'h22, 8'h33, 0, 0, 0, 8'h00, 3'b000, 0, 0);
        add(0, 3'b111, 8'h11, 8'h22, 8'h33, 0, 0, 1, 8'h11, 3'b000, 0, 0);
        add(0, 3'b111, 8'h11, 8'h22, 8'h33, 1, 32'h100, 1, 8'h11, 3'b001, 32'h100, 0);
        add(0, 3'b111, 8'h11, 8'h22, 8'h33, 0, 0, 0, 8'h11, 3'b000, 0, 0);
        add(0, 3'b111, 8'h11, 8'h22, 8'h33, 0, 0, 1, 8'h22, 3'b000, 0, 0);
        add(0, 3'b111, 8'h11, 8'h22, 8'h33, 1, 32'h200, 1, 8'h22, 3'b010, 32'h200, 0);
        add(0, 3'b111, 8'h11, 8'h22, 8'h33, 0, 0, 0, 8'h22, 3'b000, 0, 0);
        add(0, 3'b111, 8'h11, 8'h22, 8'h33, 0, 0, 1, 8'h33, 3'b000, 0, 0);
        add(0, 3'b111, 8'h11, 8'h22, 8'h33, 1, 32'h300, 1, 8'h33, 3'b100, 32'h300, 0);
        // rotation: after al is served, ag beats a still-waiting al
        add(0, 3'b101, 8'h44, 0, 8'h55, 0, 0, 0, 8'h33, 3'b000, 0, 0);
        add(0, 3'b101, 8'h44, 0, 8'h55, 1, 32'h444, 1, 8'h44, 3'b001, 32'h444, 0);
        add(0, 3'b101, 8'h44, 0, 8'h55, 0, 0, 0, 8'h44, 3'b000, 0, 0);
        add(0, 3'b101, 8'h44, 0, 8'h55, 1, 32'h555, 1, 8'h55, 3'b100, 32'h555, 0);
        add(0, 3'b000, 0, 0, 0, 0, 0, 0, 8'h55, 3'b000, 0, 0);
        // locking: bj opb toggles and al waits while bj is busy
        add(1, 3'b000, 0, 0, 0, 0, 0, 0, 8'h00, 3'b000, 0, 0);
        add(0, 3'b010, 0, 8'h66, 0, 0, 0, 0, 8'h00, 3'b000, 0, 0);
        add(0, 3'b011, 8'h77, 8'h66, 0, 0, 0, 1, 8'h66, 3'b000, 0, 0);
        add(0, 3'b011, 8'h77, 8'h99, 0, 0, 0, 1, 8'h66, 3'b000, 0, 0);
        add(0, 3'b011, 8'h77, 8'h99, 0, 1, 32'h666, 1, 8'h66, 3'b010, 32'h666, 0);
        add(0, 3'b001, 8'h77, 0, 0, 0, 0, 0, 8'h66, 3'b000, 0, 0);
        add(0, 3'b001, 8'h77, 0, 0, 1, 32'h777, 1, 8'h77, 3'b001, 32'h777, 0);
        add(0, 3'b000, 0, 0, 0, 0, 0, 0, 8'h77, 3'b000, 0, 0);
        // watchdog with TMO_W=3: fires on the 7th busy cycle, then completion on the 7th wins
        add(1, 3'b000, 0, 0, 0, 0, 0, 0, 8'h00, 3'b000, 0, 0);
        add(0, 3'b100, 0, 0, 8'h88, 0, 0, 0, 8'h00, 3'b000, 0, 0);
        for (int i = 0; i < 6; i++) add(0, 3'b100, 0, 0, 8'h88, 0, 32'hDEAD, 1, 8'h88, 3'b000, 0, 0);
        add(0, 3'b100, 0, 0, 8'h88, 0, 32'hDEAD, 1, 8'h88, 3'b100, 0, 1);
        add(0, 3'b100, 0, 0, 8'h89, 0, 0, 0, 8'h88, 3'b000, 0, 0);
        for (int i = 0; i < 6; i++) add(0, 3'b100, 0, 0, 8'h89, 0, 0, 1, 8'h89, 3'b000, 0, 0);
        add(0, 3'b100, 0, 0, 8'h89, 1, 32'hABC, 1, 8'h89, 3'b100, 32'hABC, 0);
        add(0, 3'b000, 0, 0, 0, 0, 0, 0, 8'h89, 3'b000, 0, 0);
        // async reset mid-busy, then al wins an al/ag tie
        add(0, 3'b010, 0, 8'h5A, 0, 0, 0, 0, 8'h89, 3'b000, 0, 0);
        add(0, 3'b010, 0, 8'h5A, 0, 0, 0, 1, 8'h5A, 3'b000, 0, 0);
        add(1, 3'b010, 0, 8'h5A, 0, 1, 32'hFFFF, 0, 8'h00, 3'b000, 0, 0);
        add(0, 3'b101, 8'hAA, 0, 8'hBB, 0, 0, 0, 8'h00, 3'b000, 0, 0);
        add(0, 3'b101, 8'hAA, 0, 8'hBB, 1, 32'hAAAA, 1, 8'hAA, 3'b001, 32'hAAAA, 0);
        add(0, 3'b000, 0, 0, 0, 0, 0, 0, 8'hAA, 3'b000, 0, 0);

        // Inputs change on the falling edge; outputs are sampled 1 time unit before the rising edge.
        foreach (vq[i]) begin
            @(negedge clk);
            rst = vq[i].r;
            {ag_val, bj_val, al_val} = vq[i].v;
            al_opb = vq[i].a; bj_opb = vq[i].b; ag_opb = vq[i].g;
            cal_rdy = vq[i].cr; cal_res = vq[i].cres;
            #4;
            checks++;
            if ({arb_val, cal_opb, rdy, res, tmo} !== {vq[i].ev, vq[i].eo, vq[i].erdy, vq[i].eres, vq[i].et}) begin
                errors++;
                $display("FAIL vec%0d got val=%b opb=%h rdy=%b res=%h tmo=%b want val=%b opb=%h rdy=%b res=%h tmo=%b",
                         i, arb_val, cal_opb, rdy, res, tmo, vq[i].ev, vq[i].eo, vq[i].erdy, vq[i].eres, vq[i].et);
            end
        end

        // fairness: all three held high, single-cycle ops, grants must rotate al, bj, ag
        @(negedge clk);
        rst = 1'b1; cal_rdy = 1'b0;
        {ag_val, bj_val, al_val} = 3'b000;
        @(negedge clk);
        rst = 1'b0;
        {ag_val, bj_val, al_val} = 3'b111;
        al_opb = 8'hC1; bj_opb = 8'hC2; ag_opb = 8'hC3;
        for (int k = 0; k < 9; k++) begin
            logic [2:0] ex;
            logic [7:0] eo;
            bit         got;
            ex = 3'b001 << (k % 3);
            eo = 8'hC1 + 8'(k % 3);
            got = 1'b0;
            for (int n = 0; n < 6 && !got; n++) begin
                @(negedge clk);
                cal_rdy = arb_val;
                cal_res = 32'(k);
                #4;
                if (|rdy) got = 1'b1;
            end
            checks++;
            if (!got || rdy !== ex || cal_opb !== eo || res !== 32'(k)) begin
                errors++;
                $display("FAIL fair%0d got seen=%0d rdy=%b opb=%h res=%h want rdy=%b opb=%h res=%h",
                         k, got, rdy, cal_opb, res, ex, eo, 32'(k));
            end
        end
        @(negedge clk);
        cal_rdy = 1'b0;
        {ag_val, bj_val, al_val} = 3'b000;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
